// File: rtl/if_integrator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_integrator_pkg
// Description : Shared state encoding and width check for the IF integrator.
// Revision    : 1.0  initial release
// ============================================================================
package if_integrator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_INTEGRATE = 2'd2
    } state_t;

    // True when the accumulator can hold the largest possible sum without wrapping
    function automatic bit acc_width_ok(input int acc_w, input int if_w, input int cnt_w);
        return acc_w >= (if_w + cnt_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_integrator_if.sv
`default_nettype none
// ============================================================================
// Module      : if_integrator_if
// Description : Sample stream, step control and result bus of the IF integrator.
//               master = producer/consumer side, slave = integrator.
// Revision    : 1.0  initial release
// ============================================================================
interface if_integrator_if #(
    parameter int IF_WIDTH  = 32,
    parameter int CNT_WIDTH = 16,
    parameter int ACC_WIDTH = 48,
    parameter int IDX_WIDTH = 10
);
    logic signed [IF_WIDTH-1:0]  if_in;
    logic                        if_valid;
    logic                        step_start;
    logic        [CNT_WIDTH-1:0] settle_len;
    logic        [CNT_WIDTH-1:0] int_len;
    logic signed [ACC_WIDTH-1:0] sum_out;
    logic        [IDX_WIDTH-1:0] idx_out;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;
    logic                        overrun;
    logic                        aborted;

    modport master (
        output if_in, if_valid, step_start, settle_len, int_len, out_ready,
        input  sum_out, idx_out, out_valid, busy, overrun, aborted
    );

    modport slave (
        input  if_in, if_valid, step_start, settle_len, int_len, out_ready,
        output sum_out, idx_out, out_valid, busy, overrun, aborted
    );
endinterface
`default_nettype wire

// File: rtl/if_integrator_result_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_result_reg
// Description : Single-entry valid/ready result register. A load arriving
//               while a result is pending and not being taken is dropped and
//               flagged in the sticky overrun bit.
// Revision    : 1.0  initial release
// ============================================================================
module if_result_reg #(
    parameter int ACC_WIDTH = 48,
    parameter int IDX_WIDTH = 10
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        load,
    input  wire logic signed [ACC_WIDTH-1:0] load_sum,
    input  wire logic        [IDX_WIDTH-1:0] load_idx,
    input  wire logic                        out_ready,
    output      logic signed [ACC_WIDTH-1:0] sum_out,
    output      logic        [IDX_WIDTH-1:0] idx_out,
    output      logic                        out_valid,
    output      logic                        overrun
);
    logic signed [ACC_WIDTH-1:0] r_sum;
    logic        [IDX_WIDTH-1:0] r_idx;
    logic                        r_valid;
    logic                        r_overrun;
    logic                        w_blocked;

    // Entry is full and the consumer is not draining it this cycle
    assign w_blocked = r_valid && !out_ready;

    // Load/drain the single entry; a blocked load keeps the old result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (load) begin
            if (w_blocked) begin
                r_overrun <= 1'b1;
            end else begin
                r_sum   <= load_sum;
                r_idx   <= load_idx;
                r_valid <= 1'b1;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign sum_out   = r_sum;
    assign idx_out   = r_idx;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: rtl/if_integrator.sv
`default_nettype none
// ============================================================================
// Module      : if_integrator
// Description : Accumulate-and-dump stage after the IF mixer. Per frequency
//               step: discard settle_len valid samples, sum int_len valid
//               samples, hand the sum and step index to a result register.
// Revision    : 1.0  initial release
// ============================================================================
module if_integrator
    import if_integrator_pkg::*;
#(
    parameter int IF_WIDTH  = 32,
    parameter int CNT_WIDTH = 16,
    parameter int ACC_WIDTH = 48,
    parameter int IDX_WIDTH = 10
) (
    input  wire logic       clk,
    input  wire logic       rst,
    if_integrator_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] c_IDX_ONE = IDX_WIDTH'(1);

    generate
        if (!acc_width_ok(ACC_WIDTH, IF_WIDTH, CNT_WIDTH)) begin : g_acc_width_check
            $error("if_integrator: ACC_WIDTH must be >= IF_WIDTH + CNT_WIDTH");
        end
    endgenerate

    state_t                      r_state, w_state_nxt, w_cur_state;
    logic        [CNT_WIDTH-1:0] r_settle_cnt, w_settle_nxt, w_cur_settle;
    logic        [CNT_WIDTH-1:0] r_int_cnt, w_int_nxt, w_cur_int;
    logic signed [ACC_WIDTH-1:0] r_acc, w_acc_nxt, w_cur_acc;
    logic signed [ACC_WIDTH-1:0] w_sample;
    logic        [IDX_WIDTH-1:0] r_step_cnt, r_cur_idx, w_cur_idx;
    logic                        r_aborted;
    logic                        w_done;

    assign w_sample = {{(ACC_WIDTH-IF_WIDTH){bus.if_in[IF_WIDTH-1]}}, bus.if_in};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and datapath: a step_start first re-seeds the step, then the
    // same-cycle sample is applied to that fresh step
    always_comb begin
        w_cur_state  = r_state;
        w_cur_settle = r_settle_cnt;
        w_cur_int    = r_int_cnt;
        w_cur_acc    = r_acc;
        w_cur_idx    = r_cur_idx;
        if (bus.step_start) begin
            w_cur_state  = (bus.settle_len != '0) ? ST_SETTLE : ST_INTEGRATE;
            w_cur_settle = bus.settle_len;
            w_cur_int    = bus.int_len;
            w_cur_acc    = '0;
            w_cur_idx    = r_step_cnt;
        end
        w_state_nxt  = w_cur_state;
        w_settle_nxt = w_cur_settle;
        w_int_nxt    = w_cur_int;
        w_acc_nxt    = w_cur_acc;
        w_done       = 1'b0;
        case (w_cur_state)
            ST_SETTLE: begin
                if (bus.if_valid) begin
                    w_settle_nxt = w_cur_settle - c_CNT_ONE;
                    if (w_cur_settle == c_CNT_ONE) begin
                        if (w_cur_int == '0) begin
                            w_done      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_INTEGRATE;
                        end
                    end
                end
            end
            ST_INTEGRATE: begin
                if (w_cur_int == '0) begin
                    // Zero-length integration: empty sum is ready at once
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (bus.if_valid) begin
                    w_acc_nxt = w_cur_acc + w_sample;
                    w_int_nxt = w_cur_int - c_CNT_ONE;
                    if (w_cur_int == c_CNT_ONE) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    // Counters, accumulator, step index and sticky abort flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle_cnt <= '0;
            r_int_cnt    <= '0;
            r_acc        <= '0;
            r_step_cnt   <= '0;
            r_cur_idx    <= '0;
            r_aborted    <= 1'b0;
        end else begin
            r_settle_cnt <= w_settle_nxt;
            r_int_cnt    <= w_int_nxt;
            r_acc        <= w_acc_nxt;
            r_cur_idx    <= w_cur_idx;
            if (bus.step_start) begin
                r_step_cnt <= r_step_cnt + c_IDX_ONE;
                if (r_state != ST_IDLE) r_aborted <= 1'b1;
            end
        end
    end

    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.aborted = r_aborted;

    if_result_reg #(
        .ACC_WIDTH (ACC_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_result_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (w_done),
        .load_sum  (w_acc_nxt),
        .load_idx  (w_cur_idx),
        .out_ready (bus.out_ready),
        .sum_out   (bus.sum_out),
        .idx_out   (bus.idx_out),
        .out_valid (bus.out_valid),
        .overrun   (bus.overrun)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_integrator.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_integrator
// Description : Scoreboard bench for if_integrator with directed vectors.
// Revision    : 1.0  initial release
// ============================================================================
module tb_if_integrator;
    typedef struct {
        longint sum;
        longint idx;
    } exp_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

    if_integrator_if bus ();

    if_integrator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit ss, input bit v, input int x);
        bus.step_start = ss;
        bus.if_valid   = v;
        bus.if_in      = x;
        tick();
        bus.step_start = 1'b0;
        bus.if_valid   = 1'b0;
    endtask

    task automatic push(input longint s, input longint i);
        exp_t e;
        e.sum = s;
        e.idx = i;
        sb.push_back(e);
    endtask

    task automatic set_lens(input int sl, input int il);
        bus.settle_len = sl[15:0];
        bus.int_len    = il[15:0];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sum"},     bus.sum_out,   0);
        check({tag, "_idx"},     bus.idx_out,   0);
        check({tag, "_valid"},   bus.out_valid, 0);
        check({tag, "_busy"},    bus.busy,      0);
        check({tag, "_overrun"}, bus.overrun,   0);
        check({tag, "_aborted"}, bus.aborted,   0);
    endtask

    // Monitor: every accepted result is compared against the next expectation
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got sum %0d idx %0d expected no result",
                         bus.sum_out, bus.idx_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_sum", bus.sum_out, e.sum);
                check("sb_idx", bus.idx_out, e.idx);
            end
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        bus.if_in = '0; bus.if_valid = 1'b0; bus.step_start = 1'b0;
        bus.settle_len = '0; bus.int_len = '0; bus.out_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        tick(); tick();
        rst = 1'b0;
        tick();

        // Settle 3, integrate 4: 10,20,30 discarded, 1+2+3+4 = 10
        set_lens(3, 4);
        push(10, 0);
        cyc(1, 1, 10);
        cyc(0, 1, 20);
        cyc(0, 1, 30);
        check("t1_busy", bus.busy, 1);
        cyc(0, 1, 1);
        cyc(0, 1, 2);
        cyc(0, 1, 3);
        check("t1_valid_early", bus.out_valid, 0);
        cyc(0, 1, 4);
        check("t1_valid_lat", bus.out_valid, 1);
        check("t1_busy_done", bus.busy, 0);
        tick();
        check("t1_drained", bus.out_valid, 0);

        // Full-scale negative input for the longest integration: no wrap
        set_lens(0, 65535);
        push(-64'sd140735340871680, 1);
        bus.step_start = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus.if_valid = 1'b1;
            bus.if_in    = 32'sh8000_0000;
            tick();
            bus.step_start = 1'b0;
        end
        bus.if_valid = 1'b0;
        tick();

        // Gaps in if_valid stall the count: 5 + 7 = 12
        set_lens(0, 2);
        push(12, 2);
        cyc(1, 1, 5);
        cyc(0, 0, 99);
        check("t3_gap_valid", bus.out_valid, 0);
        check("t3_gap_busy", bus.busy, 1);
        cyc(0, 1, 7);
        check("t3_done", bus.out_valid, 1);
        tick();

        // Abort mid-integration after a fresh reset: partial sum never appears
        rst = 1'b1; tick(); rst = 1'b0; tick();
        set_lens(0, 4);
        cyc(1, 1, 1);
        cyc(0, 1, 2);
        set_lens(0, 1);
        push(100, 1);
        cyc(1, 1, 100);
        check("t4_aborted", bus.aborted, 1);
        tick();

        // Consumer stalled across two steps: first kept, second dropped
        bus.out_ready = 1'b0;
        set_lens(0, 1);
        push(7, 2);
        cyc(1, 1, 7);
        tick();
        check("t5_overrun_clear", bus.overrun, 0);
        cyc(1, 1, 9);
        tick();
        check("t5_overrun_set", bus.overrun, 1);
        check("t5_hold_sum", bus.sum_out, 7);
        check("t5_hold_idx", bus.idx_out, 2);
        bus.out_ready = 1'b1;
        tick();
        check("t5_drained", bus.out_valid, 0);

        // Accept and load in the same cycle: valid stays high
        bus.out_ready = 1'b0;
        push(3, 4);
        cyc(1, 1, 3);
        bus.out_ready = 1'b1;
        push(4, 5);
        cyc(1, 1, 4);
        check("t5_b2b_valid", bus.out_valid, 1);
        tick();
        check("t5_b2b_drained", bus.out_valid, 0);

        // Reset asynchronously during settle with a pending result and flags set
        bus.out_ready = 1'b0;
        cyc(1, 1, 11);
        set_lens(5, 3);
        cyc(1, 1, 1);
        cyc(0, 1, 2);
        check("t6_pre_busy", bus.busy, 1);
        check("t6_pre_valid", bus.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        set_lens(0, 0);
        push(0, 0);
        cyc(1, 0, 0);
        check("t6_zero_len_valid", bus.out_valid, 1);

        begin
            int budget;
            budget = 20;
            while (sb.size() != 0 && budget > 0) begin
                tick();
                budget--;
            end
        end
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
